alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU in the execute stage between two requesters: requester 0 is the main EX path and requester 1 is the branch-compare/auxiliary path.
- Uses round-robin arbitration with a req/gnt handshake on the request side.
- Drives the ALU operand and control inputs from the granted requester and registers the result into a one-entry response slot with valid/ready backpressure.
- Sits between the ID/EX pipeline register and the ALU; the EX/MEM register consumes the response.

Parameters:
- WIDTH, 32, operand/result width
- CTRL_W, 3, ALU control width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 wants an ALU op
- ctrl0  input  CTRL_W  requester 0 ALU control
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- gnt0  output  1  requester 0 granted this cycle (combinational)
- req1, ctrl1, a1, b1, gnt1  same as above, for requester 1
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_control  output  CTRL_W  to ALU control
- alu_result  input  WIDTH  from ALU result
- alu_zero  input  1  from ALU zero
- rsp_valid  output  1  response slot full
- rsp_id  output  1  requester that owns the response
- rsp_result  output  WIDTH  registered result
- rsp_zero  output  1  registered zero flag
- rsp_err  output  1  op used an illegal control code
- rsp_ready  input  1  consumer accepts the response

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, last_gnt=1 (so requester 0 wins the first contest). gnt0/gnt1 are forced 0 while reset is asserted.
- Slot free condition: free = !rsp_valid || rsp_ready.
- Grant (combinational), only when free:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: grant the requester != last_gnt.
  - Neither asserts req, or !free: no grant.
- At most one of gnt0/gnt1 is high in any cycle.
- ALU drive:
  - Granted: alu_a/alu_b/alu_control = granted requester's a/b/ctrl.
  - Not granted: alu_a=0, alu_b=0, alu_control=3'b011 (the don't-care code).
- Clock edge with a grant:
  - rsp_valid<=1, rsp_id<=granted index, last_gnt<=granted index.
  - rsp_result<=alu_result, rsp_zero<=alu_zero.
  - Latency is one cycle: the response is visible in the cycle after gnt.
- Legal control codes are 010 (add), 110 (sub), 000 (and), 001 (or) and 111 (slt). Codes 011/100/101 are illegal. If the granted ctrl is illegal: rsp_err<=1, rsp_result<=0, rsp_zero<=1. ALU X output must never be captured.
- Clock edge with no grant: if rsp_valid && rsp_ready then rsp_valid<=0; all other regs hold.
- Throughput: when rsp_ready is held high, one op per cycle, with back-to-back grants and the slot refilled on the same edge it drains.
- Backpressure: while rsp_valid && !rsp_ready, the slot holds (rsp_* stable), no grants are issued and requesters stall.
- Requester rules: a requester holds req, ctrl, a and b stable until it sees gnt. Operands are sampled only in the gnt cycle. Dropping req before grant is legal and has no side effect.
- Reset mid-operation: a pending response is discarded and the round-robin pointer returns to its reset state.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - Adds ports lock0/lock1 (input, 1 bit).
  - If the requester granted on the previous edge has lock high and req high, it alone is eligible for the next grant, regardless of round-robin; the other requester is blocked.
  - Lock has no effect when that requester's req is low.
  - last_gnt updates normally.
- Undefined: no lock ports; pure round-robin as described above.

Test Plan:
- Reset then single request: req0=1, ctrl0=010, a0=5, b0=7 -> gnt0=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Contention with rsp_ready=1: req0 and req1 held high for 4 cycles -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1 with rsp_valid high every cycle.
- Backpressure: response pending with rsp_ready=0 for 3 cycles while req1=1 -> gnt1=0 throughout and rsp_* unchanged; rsp_ready=1 -> gnt1=1 that same cycle and new response on the next edge.
- Illegal op: ctrl1=100, a1=1, b1=1 -> rsp_err=1, rsp_result=0, rsp_zero=1, rsp_id=1.
- Sub zero flag plus async reset: ctrl0=110, a0=b0=32'h80000000 -> rsp_result=0, rsp_zero=1; then drop rst_n mid-cycle with rsp_valid=1 -> rsp_valid=0 immediately, and the next contest is won by requester 0.
- ALU_ARB_LOCK_EN: req0=lock0=1 held with req1=1 -> gnt0 on 3 consecutive cycles; lock0 drops -> gnt1 on the next cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between the main EX path
// (requester 0) and the branch-compare/auxiliary path (requester 1).
// The granted op's ALU result is captured in a one-entry response slot with
// valid/ready backpressure. Illegal control codes are flagged with rsp_err
// and never let the ALU output into the slot.
// Optional build macro ALU_ARB_LOCK_EN adds lock0/lock1 inputs. A requester
// that was granted on the previous edge and still holds req and lock keeps
// the ALU, and the other requester is blocked.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [CTRL_W-1:0] ctrl0,
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  b0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [CTRL_W-1:0] ctrl1,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b1,
  output logic              gnt1,
`ifdef ALU_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  // Code driven to the ALU when nobody holds the grant.
  localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(3'b011);

  // add, sub, and, or, slt are the only codes the ALU implements.
  function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
    ctrl_legal = (c == CTRL_W'(3'b010)) || (c == CTRL_W'(3'b110)) ||
                 (c == CTRL_W'(3'b000)) || (c == CTRL_W'(3'b001)) ||
                 (c == CTRL_W'(3'b111));
  endfunction

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             last_gnt_q, last_gnt_d;
`ifdef ALU_ARB_LOCK_EN
  logic             gnt_prev_q, gnt_prev_d;
`endif

  logic slot_free;
  logic elig0, elig1;
  logic gnt0_c, gnt1_c;

  // Grant decision: round-robin between eligible requesters, only when the
  // response slot can take a new result, never while reset is asserted.
  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned infers a latch.
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    elig0     = req0;
    elig1     = req1;
`ifdef ALU_ARB_LOCK_EN
    if (gnt_prev_q && !last_gnt_q && lock0 && req0) elig1 = 1'b0;
    if (gnt_prev_q &&  last_gnt_q && lock1 && req1) elig0 = 1'b0;
`endif
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && slot_free) begin
      if (elig0 && elig1) begin
        if (last_gnt_q) gnt0_c = 1'b1;
        else            gnt1_c = 1'b1;
      end else begin
        gnt0_c = elig0;
        gnt1_c = elig1;
      end
    end
  end

  assign gnt0 = gnt0_c;
  assign gnt1 = gnt1_c;

  // ALU operand mux: granted requester's operands, otherwise a quiet idle op.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = CTRL_IDLE;
    if (gnt0_c) begin
      alu_a       = a0;
      alu_b       = b0;
      alu_control = ctrl0;
    end else if (gnt1_c) begin
      alu_a       = a1;
      alu_b       = b1;
      alu_control = ctrl1;
    end
  end

  // Response slot next state: fill on a grant, drain on accept, else hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    last_gnt_d   = last_gnt_q;
`ifdef ALU_ARB_LOCK_EN
    gnt_prev_d   = gnt0_c || gnt1_c;
`endif
    if (gnt0_c || gnt1_c) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt1_c;
      last_gnt_d  = gnt1_c;
      if (ctrl_legal(alu_control)) begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
      end else begin
        // The ALU output is undefined for these codes; keep it out of the slot.
        rsp_result_d = '0;
        rsp_zero_d   = 1'b1;
        rsp_err_d    = 1'b1;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to 1 so requester 0 wins first.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_gnt_q   <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
      gnt_prev_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      last_gnt_q   <= last_gnt_d;
`ifdef ALU_ARB_LOCK_EN
      gnt_prev_q   <= gnt_prev_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule
